noc_port_adapter: RTL

- Router-side end of the core network interface: drains the NI outbound async FIFO read port and injects 32-bit packets into the local router; accepts packets ejected by the router and fills the NI inbound async FIFO write port.
- Packet format: [DSIZE-1:RSIZE] = destination router address; [RSIZE-1:0] = neuron address/data.
- Sits in the NoC clock domain, one instance per router local port.

---
 rtl/noc_port_adapter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/noc_port_adapter.sv
// Router-side NoC port adapter: injects outbound-FIFO packets into the router and
// writes router-ejected local packets into the inbound FIFO. Optional macro: LOOPBACK_EN.
module noc_port_adapter #(
   parameter int unsigned MSB_SLOT   = 5,
   parameter logic [15:0] LOCAL_ADDR = 16'h0000,
   parameter int unsigned CNT_W      = 16,
   localparam int unsigned DSIZE     = 1 << MSB_SLOT,
   localparam int unsigned RSIZE     = DSIZE / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DSIZE-1:0] fifo_rdata,
   input  logic             fifo_rempty,
   output logic             fifo_rinc,
   output logic [DSIZE-1:0] fifo_wdata,
   input  logic             fifo_wfull,
   output logic             fifo_winc,
   output logic [DSIZE-1:0] out_flit,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic [DSIZE-1:0] in_flit,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [CNT_W-1:0] tx_count,
   output logic [CNT_W-1:0] rx_count,
   output logic [CNT_W-1:0] drop_count
);

   localparam logic [RSIZE-1:0] L_LOCAL_ADDR = RSIZE'(LOCAL_ADDR);

`ifdef LOOPBACK_EN
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_LOOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SEND} state_t;
`endif

   state_t           r_state;
   state_t           w_next_state;
   state_t           w_head_state;
   logic [DSIZE-1:0] r_out_flit;
   logic [CNT_W-1:0] r_tx_count;
   logic [CNT_W-1:0] r_rx_count;
   logic [CNT_W-1:0] r_drop_count;
   logic             w_capture;
   logic             w_tx_inc;
   logic             w_push;
   logic             w_drop;
   logic             w_in_local;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + 1'b1;
   endfunction

`ifdef LOOPBACK_EN
   logic w_head_local;
   assign w_head_local = (fifo_rdata[DSIZE-1:RSIZE] == L_LOCAL_ADDR);
   assign w_head_state = w_head_local ? S_LOOP : S_SEND;
`else
   assign w_head_state = S_SEND;
`endif

   // NOTE: every output of a combinational block gets a default first, so no path
   // through the case/if tree leaves a signal unassigned and infers a latch.
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_tx_inc     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!fifo_rempty) begin
               w_capture    = 1'b1;
               w_next_state = w_head_state;
            end
         end
         S_SEND: begin
            if (out_ready) begin
               w_tx_inc = 1'b1;
               if (!fifo_rempty) begin
                  w_capture    = 1'b1;
                  w_next_state = w_head_state;
               end else begin
                  w_next_state = S_IDLE;
               end
            end
         end
`ifdef LOOPBACK_EN
         S_LOOP: begin
            if (!fifo_wfull) begin
               w_tx_inc     = 1'b1;
               w_next_state = S_IDLE;
            end
         end
`endif
         default: w_next_state = S_IDLE;
      endcase
   end

   assign w_in_local = (in_flit[DSIZE-1:RSIZE] == L_LOCAL_ADDR);

   // Eject path is pure wiring; a loopback packet borrows the inbound FIFO and stalls the router.
   always_comb begin
      fifo_wdata = in_flit;
      in_ready   = w_in_local ? !fifo_wfull : 1'b1;
      w_push     = in_valid && w_in_local && !fifo_wfull;
      w_drop     = in_valid && !w_in_local;
`ifdef LOOPBACK_EN
      if (r_state == S_LOOP) begin
         fifo_wdata = r_out_flit;
         in_ready   = 1'b0;
         w_push     = !fifo_wfull;
         w_drop     = 1'b0;
      end
`endif
   end

   // NOTE: the FIFO strobes are combinational, so they are gated with rst_n to keep
   // the FIFOs untouched while the adapter is held in reset.
   assign fifo_rinc = rst_n && w_capture;
   assign fifo_winc = rst_n && w_push;

   assign out_valid  = (r_state == S_SEND);
   assign out_flit   = r_out_flit;
   assign tx_count   = r_tx_count;
   assign rx_count   = r_rx_count;
   assign drop_count = r_drop_count;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_out_flit   <= '0;
         r_tx_count   <= '0;
         r_rx_count   <= '0;
         r_drop_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_capture) r_out_flit   <= fifo_rdata;
         if (w_tx_inc)  r_tx_count   <= sat_inc(r_tx_count);
         if (w_push)    r_rx_count   <= sat_inc(r_rx_count);
         if (w_drop)    r_drop_count <= sat_inc(r_drop_count);
      end
   end

endmodule
